// File: rtl/feeder_bus_master.sv
// feeder_bus_master: bus initiator that writes operands A and B to an accelerator,
// then reads its result back, with a per-transaction ready_i timeout.
module feeder_bus_master #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'hC4000000,
  parameter int unsigned     TIMEOUT   = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [XLEN-1:0] cmd_a_i,
  input  logic [XLEN-1:0] cmd_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o,
  output logic            en_o,
  output logic            we_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] data_o,
  input  logic            ready_i,
  input  logic [XLEN-1:0] data_i,
  output logic            busy_o
);
  typedef enum logic [2:0] {IDLE, WR_A, GAP_A, WR_B, GAP_B, RD_RES, RSP} state_t;
  localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] ADDR_B    = BASE_ADDR + XLEN'(4);
  localparam logic [XLEN-1:0] ADDR_RES  = BASE_ADDR + XLEN'(8);
  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [15:0]     wait_q, wait_d;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wait_q     <= wait_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wait_d     = wait_q;
    en_o       = 1'b0;
    we_o       = 1'b0;
    addr_o     = '0;
    data_o     = '0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        a_d     = cmd_a_i;
        b_d     = cmd_b_i;
        wait_d  = '0;
        state_d = WR_A;
      end
      WR_A, WR_B, RD_RES: begin
        en_o   = 1'b1;
        we_o   = state_q != RD_RES;
        addr_o = state_q == WR_A ? BASE_ADDR : state_q == WR_B ? ADDR_B : ADDR_RES;
        data_o = state_q == WR_A ? a_q : state_q == WR_B ? b_q : '0;
        wait_d = wait_q + 16'd1;
        // ready_i takes priority over a timeout landing in the same cycle
        if (ready_i) begin
          state_d = state_q == WR_A ? GAP_A : state_q == WR_B ? GAP_B : RSP;
          if (state_q == RD_RES) begin
            rsp_data_d = data_i;
            rsp_err_d  = 1'b0;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d    = RSP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      GAP_A: begin
        wait_d  = '0;
        state_d = WR_B;
      end
      GAP_B: begin
        wait_d  = '0;
        state_d = RD_RES;
      end
      RSP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready_o = state_q == IDLE;
  assign busy_o      = state_q != IDLE;
  assign rsp_valid_o = state_q == RSP;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
endmodule

// File: doc/feeder_bus_master.md
FEEDER_BUS_MASTER -- requirements
Module: feeder_bus_master

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, data and address width.
- BASE_ADDR, 32'hC4000000, operand A register; B at BASE_ADDR+4, result at BASE_ADDR+8.
- TIMEOUT, 255, maximum wait cycles for ready_i per bus transaction (1..65535).

REQ-002 Ports SHALL be, one per line:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  operand pair offered.
- cmd_ready_o  out  1  block accepts the operand pair.
- cmd_a_i  in  XLEN  operand A.
- cmd_b_i  in  XLEN  operand B.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  consumer takes the result.
- rsp_data_o  out  XLEN  result word read from the accelerator.
- rsp_err_o  out  1  transaction timed out; rsp_data_o is 0.
- en_o  out  1  device bus enable.
- we_o  out  1  device bus write (1) or read (0).
- addr_o  out  XLEN  device bus address.
- data_o  out  XLEN  device bus write data.
- ready_i  in  1  device bus completion from the accelerator.
- data_i  in  XLEN  device bus read data.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-003 The block SHALL be the bus initiator: per command it writes A, writes B, then reads the result from the accelerator.
REQ-004 The FSM states SHALL be IDLE, WR_A, GAP_A, WR_B, GAP_B, RD_RES, RSP.
REQ-005 cmd_ready_o SHALL equal 1 only in IDLE; a handshake (cmd_valid_i and cmd_ready_o) SHALL latch A and B and move to WR_A.
REQ-006 WR_A SHALL drive en_o=1, we_o=1, addr_o=BASE_ADDR, data_o=A, all held stable until ready_i=1 is sampled, then go to GAP_A.
REQ-007 GAP_A and GAP_B SHALL each last exactly one cycle with en_o=0; ready_i SHALL be ignored during gap cycles.
REQ-008 WR_B SHALL drive en_o=1, we_o=1, addr_o=BASE_ADDR+4, data_o=B, hold until ready_i=1, then go to GAP_B.
REQ-009 RD_RES SHALL drive en_o=1, we_o=0, addr_o=BASE_ADDR+8, data_o=0; on ready_i=1 it SHALL capture data_i into rsp_data_o, clear rsp_err_o and go to RSP.
REQ-010 RSP SHALL hold rsp_valid_o=1 and en_o=0 until rsp_ready_i=1, then return to IDLE; rsp_data_o and rsp_err_o SHALL stay stable while rsp_valid_o=1.
REQ-011 Minimum latency SHALL be 6 cycles from command handshake to rsp_valid_o, with ready_i returned one cycle after each request.
REQ-012 A wait counter SHALL clear on entry to WR_A, WR_B and RD_RES and increment each cycle ready_i=0.
REQ-013 If the wait counter reaches TIMEOUT, the block SHALL deassert en_o, set rsp_err_o=1 and rsp_data_o=0, and go to RSP.
REQ-014 When ready_i=1 and the counter reaches TIMEOUT in the same cycle, ready_i SHALL win and no error is flagged.
REQ-015 ready_i asserted in IDLE, GAP or RSP SHALL have no effect.
REQ-016 cmd_valid_i while busy SHALL not be accepted and SHALL not disturb the latched operands.
REQ-017 rsp_ready_i asserted in the same cycle rsp_valid_o rises SHALL complete the response; IDLE is entered the next cycle.
REQ-018 When en_o=0, addr_o, we_o and data_o SHALL be 0.

Reset
REQ-019 rst_i=0 SHALL asynchronously force IDLE with all outputs 0 except cmd_ready_o=1, and clear the counter and latched operands.
REQ-020 A reset asserted mid-transaction SHALL drop en_o immediately and abandon the command with no response.
REQ-021 After release of rst_i, the first command SHALL be acceptable on the first rising edge.

Verification
REQ-022 Command A=32'h3F800000, B=32'h40000000; responder readies one cycle after each request and returns 32'h40400000 -> bus writes C4000000/3F800000 and C4000004/40000000, each followed by one en_o=0 cycle, then a read of C4000008; rsp_data_o=32'h40400000, rsp_err_o=0, rsp_valid_o 6 cycles after the handshake.
REQ-023 Responder delays the result read by 10 cycles (TIMEOUT=255) -> en_o, addr_o=C4000008 and we_o=0 held stable for 11 cycles; response correct.
REQ-024 TIMEOUT=8 and responder never asserts ready_i on WR_B -> en_o drops after 8 wait cycles; rsp_err_o=1, rsp_data_o=0; no read is issued.
REQ-025 rsp_ready_i held low for 5 cycles while a second command is pending -> cmd_ready_o stays 0 and rsp_data_o is stable; the second command is accepted the cycle after IDLE is re-entered.
REQ-026 rst_i pulsed low during RD_RES -> en_o=0 immediately and no rsp_valid_o; a new command afterwards completes normally.
